// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Two-requester arbiter in front of the SDRAM controller's Avalon-MM slave.
//   Requester 0 (Saturn A-bus) has priority. Requester 1 (SPI/audio DMA) wins
//   after STARVE_LIMIT consecutive lost arbitrations. One command is in flight
//   toward the controller at a time. In-order read responses are routed back to
//   the requester that issued them by a small tag FIFO.
//
// Ports
//   clock, reset                 system clock, async active-high reset
//   m0_* / m1_*                  requester Avalon-MM master side
//   m_readdata                   shared response data (both requesters)
//   s_*                          controller Avalon-MM slave side
//   drop_error                   sticky: a response arrived with no tag queued
module sdram_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [1:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [1:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,

  output logic [DATA_W-1:0] m_readdata,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [1:0]        s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,

  output logic              drop_error
);

  localparam int CNT_W    = $clog2(MAX_PENDING + 1);
  localparam int PTR_W    = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;

  logic [STARVE_W-1:0] starve_cnt, starve_nxt;

  logic [MAX_PENDING-1:0] tag_mem;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;

  logic fifo_full, fifo_empty;
  logic req0, req1, elig0, elig1, pick1, starve_sat;
  logic sel_read, sel_write;
  logic accept, push, pop, head;

  assign fifo_full  = (count == CNT_W'(MAX_PENDING));
  assign fifo_empty = (count == '0);

  // A read counts only while the tag FIFO has room; writes are always eligible.
  // Read+write together is treated as a read, so it is also blocked at full.
  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign elig0 = req0 & ~(m0_read & fifo_full);
  assign elig1 = req1 & ~(m1_read & fifo_full);

  assign starve_sat = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
  assign pick1      = elig1 & (~elig0 | starve_sat);

  assign sel_read  = grant ? m1_read  : m0_read;
  assign sel_write = grant ? m1_write : m0_write;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    accept         = 1'b0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    s_address      = grant ? m1_address    : m0_address;
    s_writedata    = grant ? m1_writedata  : m0_writedata;
    s_byteenable   = grant ? m1_byteenable : m0_byteenable;

    unique case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          grant_nxt = pick1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_read  = sel_read;
        s_write = sel_write & ~sel_read;
        if (grant) m1_waitrequest = s_waitrequest;
        else       m0_waitrequest = s_waitrequest;
        // A requester that withdraws its command is simply released.
        if (!(sel_read | sel_write)) begin
          state_nxt = IDLE;
        end else if (!s_waitrequest) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!req1) begin
      starve_nxt = '0;
    end else if (state == IDLE && (elig0 | elig1)) begin
      if (pick1)            starve_nxt = '0;
      else if (!starve_sat) starve_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Tag FIFO: one bit per outstanding read naming its originator.
  assign push = accept & s_read;
  assign pop  = s_readdatavalid & ~fifo_empty;
  assign head = tag_mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_error <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (s_readdatavalid && fifo_empty) drop_error <= 1'b1;
    end
  end

  assign m_readdata       = s_readdata;
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata, m_readdata, s_readdata;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid, drop_error;

  int n_assert = 0;
  int n_fail   = 0;

  sdram_port_arbiter #(
    .ADDR_W(24), .DATA_W(16), .MAX_PENDING(4), .STARVE_LIMIT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .drop_error(drop_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = 2'b11;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = 2'b11;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    #1;
    // {s_read, s_write, m0_wait, m1_wait, m0_rdv, m1_rdv, drop_error}
    chk("reset_state", {s_read, s_write, m0_waitrequest, m1_waitrequest,
                        m0_readdatavalid, m1_readdatavalid, drop_error}, 7'b0011000);
    tick(); tick();
    reset = 1'b0;

    // Single m0 read, response three cycles after accept
    m0_address = 24'h000123; m0_read = 1'b1;
    #1 chk("t1_idle_no_cmd", {s_read, m0_waitrequest}, 2'b01);
    tick();
    chk("t1_issue", {s_read, s_address, m0_waitrequest, m1_waitrequest}, {1'b1, 24'h000123, 1'b0, 1'b1});
    tick();
    m0_read = 1'b0;
    #1 chk("t1_read_one_cycle", {s_read, m0_waitrequest}, 2'b01);
    tick(); tick();
    s_readdatavalid = 1'b1; s_readdata = 16'hBEEF;
    #1 chk("t1_response", {m0_readdatavalid, m1_readdatavalid, m_readdata}, {1'b1, 1'b0, 16'hBEEF});
    tick();
    s_readdatavalid = 1'b0;

    // Both writing continuously: 8 x m0 then 1 x m1, twice
    m0_write = 1'b1; m0_writedata = 16'h0A0A;
    m1_write = 1'b1; m1_writedata = 16'h0B0B;
    for (int i = 0; i < 18; i++) begin
      tick();
      chk($sformatf("t2_grant_%0d", i), {s_write, s_writedata},
          {1'b1, ((i % 9) == 8) ? 16'h0B0B : 16'h0A0A});
      tick();
    end
    m0_write = 1'b0; m1_write = 1'b0;

    // m1 write held off by the controller for 5 cycles
    m0_address = 24'h111111; m0_writedata = 16'h1111; m0_byteenable = 2'b01;
    m1_address = 24'hABCDEF; m1_writedata = 16'h5A5A; m1_byteenable = 2'b10;
    m1_write = 1'b1; s_waitrequest = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_stall_%0d", k),
          {s_address, s_writedata, s_byteenable, s_write, s_read, m0_waitrequest, m1_waitrequest},
          {24'hABCDEF, 16'h5A5A, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1});
      tick();
    end
    s_waitrequest = 1'b0;
    #1 chk("t3_accept", {s_write, m0_waitrequest, m1_waitrequest}, 3'b110);
    tick();
    m1_write = 1'b0;
    #1 chk("t3_back_idle", {s_write, m1_waitrequest}, 2'b01);

    // Four outstanding reads fill the tag FIFO
    m0_read = 1'b1; m0_byteenable = 2'b11;
    for (int i = 0; i < 4; i++) begin
      m0_address = 24'h000100 + 24'(i);
      tick();
      chk($sformatf("t4_read_%0d", i), {s_read, s_address}, {1'b1, 24'h000100 + 24'(i)});
      tick();
    end
    m0_address = 24'h000104;
    m1_write = 1'b1; m1_address = 24'h000200; m1_writedata = 16'h7777;
    tick();
    chk("t4_write_passes_full", {s_read, s_write, s_address, m0_waitrequest}, {1'b0, 1'b1, 24'h000200, 1'b1});
    tick();
    m1_write = 1'b0;
    tick();
    chk("t4_fifth_stalled", {s_read, m0_waitrequest}, 2'b01);
    s_readdatavalid = 1'b1; s_readdata = 16'h0001;
    #1 chk("t4_first_resp", {m0_readdatavalid, m1_readdatavalid, m_readdata}, {1'b1, 1'b0, 16'h0001});
    tick();
    s_readdatavalid = 1'b0;
    #1 chk("t4_full_uses_reg_count", {s_read, m0_waitrequest}, 2'b01);
    tick();
    chk("t4_fifth_issued", {s_read, s_address}, {1'b1, 24'h000104});
    tick();
    m0_read = 1'b0;
    for (int j = 0; j < 4; j++) begin
      s_readdatavalid = 1'b1; s_readdata = 16'h0010 + 16'(j);
      #1 chk($sformatf("t4_drain_%0d", j), {m0_readdatavalid, m1_readdatavalid, m_readdata},
             {1'b1, 1'b0, 16'h0010 + 16'(j)});
      tick();
    end
    s_readdatavalid = 1'b0;

    // Interleaved reads m0, m1, m0 with in-order responses
    m0_read = 1'b1; m0_address = 24'h000300;
    tick(); tick();
    m0_read = 1'b0; m1_read = 1'b1; m1_address = 24'h000301;
    tick();
    chk("t5_m1_issue", {s_read, s_address, m1_waitrequest}, {1'b1, 24'h000301, 1'b0});
    tick();
    m1_read = 1'b0; m0_read = 1'b1; m0_address = 24'h000302;
    tick(); tick();
    m0_read = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 16'h1111;
    #1 chk("t5_resp0", {m0_readdatavalid, m1_readdatavalid, m_readdata}, {1'b1, 1'b0, 16'h1111});
    tick();
    s_readdata = 16'h2222;
    #1 chk("t5_resp1", {m0_readdatavalid, m1_readdatavalid, m_readdata}, {1'b0, 1'b1, 16'h2222});
    tick();
    s_readdata = 16'h3333;
    #1 chk("t5_resp2", {m0_readdatavalid, m1_readdatavalid, m_readdata}, {1'b1, 1'b0, 16'h3333});
    tick();
    s_readdatavalid = 1'b0;
    #1 chk("t5_no_drop", {drop_error}, 1'b0);

    // Reset with two reads outstanding, then a stale response arrives
    m0_read = 1'b1; m0_address = 24'h000400;
    tick(); tick(); tick(); tick();
    m0_read = 1'b0;
    #1 reset = 1'b1;
    #1 chk("t6_in_reset", {s_read, s_write, m0_waitrequest, m1_waitrequest,
                           m0_readdatavalid, m1_readdatavalid, drop_error}, 7'b0011000);
    tick();
    reset = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
    #1 chk("t6_stale_not_routed", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    tick();
    s_readdatavalid = 1'b0;
    #1 chk("t6_drop_error", {drop_error}, 1'b1);
    tick();
    chk("t6_drop_sticky", {drop_error, s_read, m0_waitrequest}, 3'b101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
